// File: rtl/counter_4b_ctrl_pkg.sv
// Shared definitions for the counter_4b_ctrl control stage: state encoding and
// default widths / timeout used by the top and its run-cycle counter.
package counter_4b_ctrl_pkg;

  localparam int CNT_BW_DEF      = 4;
  localparam int RUN_CYC_BW_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/counter_4b_ctrl_runcyc.sv
// Saturating run-cycle counter with synchronous clear and enable. It exposes the
// value the register will take at the next edge so the parent can capture and compare it.
module counter_4b_ctrl_runcyc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt_next
);

  logic [WIDTH-1:0] r_cnt;

  always_comb begin
    o_cnt_next = r_cnt;
    if (i_clr) begin
      o_cnt_next = '0;
    end else if (i_en && (r_cnt != '1)) begin
      o_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_next;
    end
  end

endmodule

// File: rtl/counter_4b_ctrl.sv
// Control stage for the 4-bit counter: IDLE/RUN/DONE Moore FSM driving the counter
// enable and limit. Optional RUN timeout abort is built with COUNTER_4B_CTRL_TIMEOUT_EN.
//
// Handshake: i_run is a level request sampled only in IDLE; there is no ready. A
// request seen in RUN or DONE is dropped, never queued. o_done pulses exactly once
// per accepted command.
module counter_4b_ctrl
  import counter_4b_ctrl_pkg::*;
#(
  parameter int CNT_BW      = CNT_BW_DEF,
  parameter int RUN_CYC_BW  = RUN_CYC_BW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run,
  input  logic [CNT_BW-1:0]     i_num_cnt,
  input  logic [CNT_BW-1:0]     i_cnt,
  output logic                  o_data_en,
  output logic [CNT_BW-1:0]     o_cnt_value,
  output logic                  o_idle,
  output logic                  o_running,
  output logic                  o_done,
`ifdef COUNTER_4B_CTRL_TIMEOUT_EN
  output logic                  o_timeout,
`endif
  output logic [RUN_CYC_BW-1:0] o_run_cyc
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_BW-1:0]     r_num_cnt;
  logic [RUN_CYC_BW-1:0] r_run_cyc;
  logic [RUN_CYC_BW-1:0] w_cyc_next;
  logic                  w_accept;
  logic                  w_timeout_nxt;

  assign w_accept = (r_state == S_IDLE) && i_run;

  counter_4b_ctrl_runcyc #(
    .WIDTH (RUN_CYC_BW)
  ) u_runcyc (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_accept),
    .i_en       (r_state == S_RUN),
    .o_cnt_next (w_cyc_next)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_state_nxt = (i_num_cnt != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // A match wins over a coincident timeout.
        if (i_cnt == r_num_cnt) begin
          w_state_nxt = S_DONE;
        end
`ifdef COUNTER_4B_CTRL_TIMEOUT_EN
        else if (w_cyc_next >= RUN_CYC_BW'(TIMEOUT_CYC)) begin
          w_state_nxt   = S_DONE;
          w_timeout_nxt = 1'b1;
        end
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_num_cnt <= '0;
      r_run_cyc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_num_cnt <= i_num_cnt;
      end
      // w_cyc_next already includes the final RUN cycle (or is zero from IDLE).
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
        r_run_cyc <= w_cyc_next;
      end
    end
  end

`ifdef COUNTER_4B_CTRL_TIMEOUT_EN
  logic r_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused;
  assign w_unused = w_timeout_nxt;
`endif

  assign o_idle      = (r_state == S_IDLE);
  assign o_running   = (r_state == S_RUN);
  assign o_done      = (r_state == S_DONE);
  assign o_data_en   = (r_state == S_RUN);
  assign o_cnt_value = r_num_cnt;
  assign o_run_cyc   = r_run_cyc;

endmodule

// File: tb/tb_counter_4b_ctrl.sv
// Bench for counter_4b_ctrl with a simple up-counter model on i_cnt; timeout
// sequence is included when COUNTER_4B_CTRL_TIMEOUT_EN is defined.
module tb_counter_4b_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_run;
  logic [3:0] i_num_cnt;
  logic [3:0] i_cnt;
  logic       o_data_en;
  logic [3:0] o_cnt_value;
  logic       o_idle;
  logic       o_running;
  logic       o_done;
  logic [7:0] o_run_cyc;
`ifdef COUNTER_4B_CTRL_TIMEOUT_EN
  logic       o_timeout;
`endif

  int checks = 0;
  int errors = 0;
  logic stuck = 1'b0;

  always #5 clk = ~clk;

  counter_4b_ctrl #(
    .CNT_BW      (4),
    .RUN_CYC_BW  (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_run       (i_run),
    .i_num_cnt   (i_num_cnt),
    .i_cnt       (i_cnt),
    .o_data_en   (o_data_en),
    .o_cnt_value (o_cnt_value),
    .o_idle      (o_idle),
    .o_running   (o_running),
    .o_done      (o_done),
`ifdef COUNTER_4B_CTRL_TIMEOUT_EN
    .o_timeout   (o_timeout),
`endif
    .o_run_cyc   (o_run_cyc)
  );

  // Counter model: counts up while enabled, holds zero otherwise.
  always @(posedge clk or posedge reset) begin
    if (reset) i_cnt <= 4'd0;
    else if (o_data_en && !stuck) i_cnt <= i_cnt + 4'd1;
    else if (!o_data_en) i_cnt <= 4'd0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       run;
    logic [3:0] num;
    logic       idle;
    logic       running;
    logic       data_en;
    logic       done;
    logic [3:0] cv;
    logic [7:0] rc;
  } vec_t;

  function automatic vec_t mk(logic run, logic [3:0] num, logic idle, logic running,
                              logic data_en, logic done, logic [3:0] cv, logic [7:0] rc);
    vec_t v;
    v.run = run; v.num = num; v.idle = idle; v.running = running;
    v.data_en = data_en; v.done = done; v.cv = cv; v.rc = rc;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    int waited;

    // Inputs applied before an edge, outputs expected just after it.
    vecs[0]  = mk(1, 4'd5, 0, 1, 1, 0, 4'd5, 8'd0);  // accept target 5
    vecs[1]  = mk(0, 4'd0, 0, 1, 1, 0, 4'd5, 8'd0);
    vecs[2]  = mk(0, 4'd0, 0, 1, 1, 0, 4'd5, 8'd0);
    vecs[3]  = mk(0, 4'd0, 0, 1, 1, 0, 4'd5, 8'd0);
    vecs[4]  = mk(0, 4'd0, 0, 1, 1, 0, 4'd5, 8'd0);
    vecs[5]  = mk(0, 4'd0, 0, 1, 1, 0, 4'd5, 8'd0);
    vecs[6]  = mk(0, 4'd0, 0, 0, 0, 1, 4'd5, 8'd6);  // i_cnt==5 sampled
    vecs[7]  = mk(0, 4'd0, 1, 0, 0, 0, 4'd5, 8'd6);
    vecs[8]  = mk(1, 4'd0, 0, 0, 0, 1, 4'd0, 8'd0);  // zero target: straight to DONE
    vecs[9]  = mk(0, 4'd0, 1, 0, 0, 0, 4'd0, 8'd0);
    vecs[10] = mk(1, 4'd2, 0, 1, 1, 0, 4'd2, 8'd3);  // accept target 2
    vecs[11] = mk(1, 4'd9, 0, 1, 1, 0, 4'd2, 8'd3);  // run in RUN ignored
    vecs[12] = mk(1, 4'd9, 0, 1, 1, 0, 4'd2, 8'd3);
    vecs[13] = mk(0, 4'd9, 0, 0, 0, 1, 4'd2, 8'd3);
    vecs[14] = mk(0, 4'd9, 1, 0, 0, 0, 4'd2, 8'd3);
    // vecs[10..12] rc stays at last value (0) until DONE; fix expected below.
    vecs[10].rc = 8'd0; vecs[11].rc = 8'd0; vecs[12].rc = 8'd0;

    // Clock/reset
    reset = 1'b1; i_run = 1'b0; i_num_cnt = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle", 32'(o_idle), 32'd1);
    chk("rst_running", 32'(o_running), 32'd0);
    chk("rst_data_en", 32'(o_data_en), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_cnt_value", 32'(o_cnt_value), 32'd0);
    chk("rst_run_cyc", 32'(o_run_cyc), 32'd0);
`ifdef COUNTER_4B_CTRL_TIMEOUT_EN
    chk("rst_timeout", 32'(o_timeout), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Table-driven sequences
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      i_run = vecs[i].run; i_num_cnt = vecs[i].num;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle", i), 32'(o_idle), 32'(vecs[i].idle));
      chk($sformatf("v%0d_running", i), 32'(o_running), 32'(vecs[i].running));
      chk($sformatf("v%0d_data_en", i), 32'(o_data_en), 32'(vecs[i].data_en));
      chk($sformatf("v%0d_done", i), 32'(o_done), 32'(vecs[i].done));
      chk($sformatf("v%0d_cnt_value", i), 32'(o_cnt_value), 32'(vecs[i].cv));
      chk($sformatf("v%0d_run_cyc", i), 32'(o_run_cyc), 32'(vecs[i].rc));
    end

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    i_run = 1'b1; i_num_cnt = 4'd7;
    @(negedge clk);
    i_run = 1'b0;
    repeat (2) @(negedge clk);
    chk("ar_pre_running", 32'(o_running), 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_data_en", 32'(o_data_en), 32'd0);
    chk("ar_running", 32'(o_running), 32'd0);
    chk("ar_idle", 32'(o_idle), 32'd1);
    chk("ar_done", 32'(o_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (o_done) ndone++;
      chk($sformatf("ar_post_idle%0d", i), 32'(o_idle), 32'd1);
    end
    chk("ar_no_done", 32'(ndone), 32'd0);
    chk("ar_cnt_value", 32'(o_cnt_value), 32'd0);

    // i_run held high: 4 RUN cycles + DONE + IDLE = period 6
    @(negedge clk);
    i_run = 1'b1; i_num_cnt = 4'd3;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2b_done%0d", i), 32'(o_done), 32'((i % 6) == 4));
      chk($sformatf("b2b_idle%0d", i), 32'(o_idle), 32'((i % 6) == 5));
      if (o_done) begin
        ndone++;
        chk($sformatf("b2b_run_cyc%0d", i), 32'(o_run_cyc), 32'd4);
      end
    end
    chk("b2b_ndone", 32'(ndone), 32'd3);
    @(negedge clk);
    i_run = 1'b0;
    waited = 0;
    while (!o_idle && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("b2b_return_idle", 32'(o_idle), 32'd1);

`ifdef COUNTER_4B_CTRL_TIMEOUT_EN
    // Counter stuck at 0, target F: DONE with timeout after 16 RUN cycles
    @(negedge clk);
    stuck = 1'b1;
    i_run = 1'b1; i_num_cnt = 4'hF;
    @(negedge clk);
    i_run = 1'b0;
    chk("to_running0", 32'(o_running), 32'd1);
    for (int i = 1; i < 16; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("to_running%0d", i), 32'(o_running), 32'd1);
      chk($sformatf("to_early%0d", i), 32'(o_timeout), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("to_done", 32'(o_done), 32'd1);
    chk("to_timeout", 32'(o_timeout), 32'd1);
    chk("to_run_cyc", 32'(o_run_cyc), 32'd16);
    @(posedge clk);
    #1;
    chk("to_idle", 32'(o_idle), 32'd1);
    chk("to_timeout_clr", 32'(o_timeout), 32'd0);
    stuck = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
